// File: rtl/slc3_control_fsm.sv
// SLC-3 ISDU: Moore FSM sequencing fetch/decode/execute; SRAM strobes held MEM_WAIT cycles per access.
// Outputs decode combinationally from state; no backpressure (fixed-length memory accesses).
module slc3_control_fsm #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [4:0] S_HALTED  = 5'd0;
    localparam logic [4:0] S_FETCH1  = 5'd1;
    localparam logic [4:0] S_FETCH2  = 5'd2;
    localparam logic [4:0] S_FETCH3  = 5'd3;
    localparam logic [4:0] S_DECODE  = 5'd4;
    localparam logic [4:0] S_ADD     = 5'd5;
    localparam logic [4:0] S_AND     = 5'd6;
    localparam logic [4:0] S_NOT     = 5'd7;
    localparam logic [4:0] S_BR_0    = 5'd8;
    localparam logic [4:0] S_BR_1    = 5'd9;
    localparam logic [4:0] S_JMP     = 5'd10;
    localparam logic [4:0] S_JSR_0   = 5'd11;
    localparam logic [4:0] S_JSR_1   = 5'd12;
    localparam logic [4:0] S_LDR_0   = 5'd13;
    localparam logic [4:0] S_LDR_1   = 5'd14;
    localparam logic [4:0] S_LDR_2   = 5'd15;
    localparam logic [4:0] S_STR_0   = 5'd16;
    localparam logic [4:0] S_STR_1   = 5'd17;
    localparam logic [4:0] S_STR_2   = 5'd18;
    localparam logic [4:0] S_PAUSE_A = 5'd19;
    localparam logic [4:0] S_PAUSE_B = 5'd20;

    localparam logic [3:0] LP_WAIT_LAST = 4'(MEM_WAIT - 1);

    logic [4:0] r_state;
    logic [4:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic       w_cnt_last;
    logic       w_mem_rd;
    logic       w_mem_wr;
    logic       w_enter_mem;

    assign w_cnt_last  = (r_cnt == 4'd0);
    assign w_mem_rd    = (r_state == S_FETCH2) || (r_state == S_LDR_1);
    assign w_mem_wr    = (r_state == S_STR_2);
    // These states always hand over to a memory state, so the counter reloads here.
    assign w_enter_mem = (r_state == S_FETCH1) || (r_state == S_LDR_0) || (r_state == S_STR_1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HALTED:  if (Run) w_state_nxt = S_FETCH1;
            S_FETCH1:  w_state_nxt = S_FETCH2;
            S_FETCH2:  if (w_cnt_last) w_state_nxt = S_FETCH3;
            S_FETCH3:  w_state_nxt = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    4'b0001: w_state_nxt = S_ADD;
                    4'b0101: w_state_nxt = S_AND;
                    4'b1001: w_state_nxt = S_NOT;
                    4'b0000: w_state_nxt = S_BR_0;
                    4'b1100: w_state_nxt = S_JMP;
                    4'b0100: w_state_nxt = S_JSR_0;
                    4'b0110: w_state_nxt = S_LDR_0;
                    4'b0111: w_state_nxt = S_STR_0;
                    4'b1101: w_state_nxt = S_PAUSE_A;
                    default: w_state_nxt = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_JMP, S_BR_1, S_JSR_1, S_LDR_2:
                       w_state_nxt = S_FETCH1;
            S_BR_0:    w_state_nxt = BEN ? S_BR_1 : S_FETCH1;
            S_JSR_0:   w_state_nxt = S_JSR_1;
            S_LDR_0:   w_state_nxt = S_LDR_1;
            S_LDR_1:   if (w_cnt_last) w_state_nxt = S_LDR_2;
            S_STR_0:   w_state_nxt = S_STR_1;
            S_STR_1:   w_state_nxt = S_STR_2;
            S_STR_2:   if (w_cnt_last) w_state_nxt = S_FETCH1;
            S_PAUSE_A: if (Continue) w_state_nxt = S_PAUSE_B;
            S_PAUSE_B: if (!Continue) w_state_nxt = S_FETCH1;
            default:   w_state_nxt = S_HALTED;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_HALTED;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_enter_mem)
                r_cnt <= LP_WAIT_LAST;
            else if ((w_mem_rd || w_mem_wr) && !w_cnt_last)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        Mem_CE     = 1'b1;
        Mem_UB     = 1'b1;
        Mem_LB     = 1'b1;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        case (r_state)
            S_FETCH1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
            end
            S_FETCH2, S_LDR_1: begin
                Mem_CE = 1'b0;
                Mem_UB = 1'b0;
                Mem_LB = 1'b0;
                Mem_OE = 1'b0;
                LD_MDR = w_cnt_last;
            end
            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_DECODE: LD_BEN = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                SR2MUX  = (r_state == S_NOT) ? 1'b0 : IR_5;
                ALUK    = (r_state == S_AND) ? 2'b01 : (r_state == S_NOT) ? 2'b10 : 2'b00;
            end
            S_BR_1: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b01;
                LD_PC    = 1'b1;
            end
            S_JMP: begin
                PCMUX = 2'b01;
                LD_PC = 1'b1;
            end
            S_JSR_0: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            S_JSR_1: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b11;
                PCMUX    = 2'b01;
                LD_PC    = 1'b1;
            end
            S_LDR_0, S_STR_0: begin
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            S_LDR_2: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S_STR_1: begin
                SR1MUX  = 1'b1;
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            S_STR_2: begin
                Mem_CE = 1'b0;
                Mem_UB = 1'b0;
                Mem_LB = 1'b0;
                Mem_WE = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
